// File: rtl/sensor_timing_sequencer_if.sv
// Control and status bundle of the sensor timing sequencer.
// The scheduler side uses master and the sequencer uses slave.
interface sensor_timing_sequencer_if #(
    parameter int NUM_CH  = 10,
    parameter int RATIO_W = 16,
    parameter int TIME_W  = 16,
    parameter int OVR_W   = 8
);
    logic                     do_auto_triggering;
    logic                     send_manual_trigger;
    logic                     event_qualifier;
    logic [RATIO_W-1:0]       user_ratio;
    logic [NUM_CH-1:0]        en_bits;
    logic [NUM_CH-1:0]        done;
    logic [TIME_W-1:0]        timeout_cycles;
    logic                     clr_isr;
    logic                     clr_stats;
    logic                     trigger;
    logic                     busy;
    logic                     sched_isr;
    logic                     timeout_isr;
    logic [NUM_CH-1:0]        timed_out;
    logic [NUM_CH*TIME_W-1:0] ch_time;
    logic [NUM_CH*TIME_W-1:0] ch_time_max;
    logic [OVR_W-1:0]         overrun_cnt;

    modport master (
        output do_auto_triggering, send_manual_trigger, event_qualifier, user_ratio,
               en_bits, done, timeout_cycles, clr_isr, clr_stats,
        input  trigger, busy, sched_isr, timeout_isr, timed_out, ch_time,
               ch_time_max, overrun_cnt
    );

    modport slave (
        input  do_auto_triggering, send_manual_trigger, event_qualifier, user_ratio,
               en_bits, done, timeout_cycles, clr_isr, clr_stats,
        output trigger, busy, sched_isr, timeout_isr, timed_out, ch_time,
               ch_time_max, overrun_cnt
    );
endinterface

// File: rtl/sensor_timing_sequencer.sv
// Issues PWM-synchronous acquisition triggers, timestamps per-channel done edges,
// aborts stuck acquisitions on timeout and keeps worst-case / overrun statistics.
module sensor_timing_sequencer #(
    parameter int NUM_CH  = 10,
    parameter int RATIO_W = 16,
    parameter int TIME_W  = 16,
    parameter int OVR_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    sensor_timing_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [RATIO_W-1:0] RATIO_ZERO = {RATIO_W{1'b0}};
    localparam logic [RATIO_W-1:0] RATIO_ONE  = {{(RATIO_W-1){1'b0}}, 1'b1};
    localparam logic [TIME_W-1:0]  TIME_ZERO  = {TIME_W{1'b0}};
    localparam logic [TIME_W-1:0]  TIME_ONE   = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [TIME_W-1:0]  TIME_MAX   = {TIME_W{1'b1}};
    localparam logic [OVR_W-1:0]   OVR_ZERO   = {OVR_W{1'b0}};
    localparam logic [OVR_W-1:0]   OVR_ONE    = {{(OVR_W-1){1'b0}}, 1'b1};
    localparam logic [OVR_W-1:0]   OVR_MAX    = {OVR_W{1'b1}};
    localparam logic [NUM_CH-1:0]  CH_ZERO    = {NUM_CH{1'b0}};

    state_t                   state_r;
    state_t                   state_next_s;
    logic [RATIO_W-1:0]       ev_cnt_r;
    logic                     mq_r;
    logic [TIME_W-1:0]        tmr_r;
    logic [NUM_CH-1:0]        en_snap_r;
    logic [NUM_CH-1:0]        captured_r;
    logic [NUM_CH-1:0]        done_ff_r;
    logic [NUM_CH-1:0]        timed_out_r;
    logic [NUM_CH*TIME_W-1:0] ch_time_r;
    logic [NUM_CH*TIME_W-1:0] ch_time_max_r;
    logic [OVR_W-1:0]         overrun_r;
    logic                     trigger_r;
    logic                     busy_r;
    logic                     sched_isr_r;
    logic                     timeout_isr_r;

    logic                     ratio_hit_s;
    logic                     auto_s;
    logic                     manual_s;
    logic                     start_s;
    logic                     in_acq_s;
    logic [NUM_CH-1:0]        cap_s;
    logic [NUM_CH-1:0]        captured_all_s;
    logic                     complete_s;
    logic                     timeout_s;

    assign in_acq_s       = (state_r == ST_ACQUIRE);
    assign ratio_hit_s    = bus.event_qualifier && (ev_cnt_r >= bus.user_ratio);
    assign auto_s         = bus.do_auto_triggering && ratio_hit_s;
    assign manual_s       = mq_r && bus.event_qualifier;
    assign start_s        = !in_acq_s && (bus.en_bits != CH_ZERO) && (auto_s || manual_s);
    assign cap_s          = bus.done & ~done_ff_r & en_snap_r & ~captured_r & {NUM_CH{in_acq_s}};
    assign captured_all_s = captured_r | cap_s;
    // Captures landing this cycle count toward completion, so completion beats a coincident timeout.
    assign complete_s     = in_acq_s && ((captured_all_s & en_snap_r) == en_snap_r);
    assign timeout_s      = in_acq_s && !complete_s && (bus.timeout_cycles != TIME_ZERO) &&
                            (tmr_r == bus.timeout_cycles);

    // Next-state decode of the acquisition FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:    if (start_s) state_next_s = ST_ACQUIRE; else state_next_s = ST_IDLE;
            ST_ACQUIRE: if (complete_s || timeout_s) state_next_s = ST_DONE; else state_next_s = ST_ACQUIRE;
            ST_DONE:    if (start_s) state_next_s = ST_ACQUIRE; else state_next_s = ST_DONE;
            default:    state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, trigger pulse and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            trigger_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            trigger_r <= start_s;
            busy_r    <= (state_next_s == ST_ACQUIRE);
        end
    end

    // Event divider and manual trigger queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_cnt_r <= RATIO_ZERO;
            mq_r     <= 1'b0;
        end else begin
            if (bus.event_qualifier) begin
                ev_cnt_r <= ratio_hit_s ? RATIO_ZERO : (ev_cnt_r + RATIO_ONE);
            end
            if (bus.send_manual_trigger) begin
                mq_r <= 1'b1;
            end else if (start_s) begin
                mq_r <= 1'b0;
            end
        end
    end

    // Acquisition timer and per-acquisition channel bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_r       <= TIME_ZERO;
            en_snap_r   <= CH_ZERO;
            captured_r  <= CH_ZERO;
            timed_out_r <= CH_ZERO;
            done_ff_r   <= CH_ZERO;
        end else begin
            done_ff_r <= bus.done;
            if (start_s) begin
                tmr_r       <= TIME_ZERO;
                en_snap_r   <= bus.en_bits;
                captured_r  <= CH_ZERO;
                timed_out_r <= CH_ZERO;
            end else begin
                if (tmr_r != TIME_MAX) begin
                    tmr_r <= tmr_r + TIME_ONE;
                end
                captured_r <= captured_all_s;
                if (timeout_s) begin
                    timed_out_r <= en_snap_r & ~captured_all_s;
                end
            end
        end
    end

    // Per-channel timestamps and worst-case times; a capture overrides clr_stats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_time_r     <= {(NUM_CH*TIME_W){1'b0}};
            ch_time_max_r <= {(NUM_CH*TIME_W){1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cap_s[i]) begin
                    ch_time_r[i*TIME_W +: TIME_W] <= tmr_r;
                end else if (timeout_s && en_snap_r[i] && !captured_all_s[i]) begin
                    ch_time_r[i*TIME_W +: TIME_W] <= TIME_MAX;
                end
                if (cap_s[i] && (bus.clr_stats || (tmr_r > ch_time_max_r[i*TIME_W +: TIME_W]))) begin
                    ch_time_max_r[i*TIME_W +: TIME_W] <= tmr_r;
                end else if (bus.clr_stats) begin
                    ch_time_max_r[i*TIME_W +: TIME_W] <= TIME_ZERO;
                end
            end
        end
    end

    // Overrun counter and sticky interrupts (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_r     <= OVR_ZERO;
            sched_isr_r   <= 1'b0;
            timeout_isr_r <= 1'b0;
        end else begin
            if (bus.clr_stats) begin
                overrun_r <= OVR_ZERO;
            end else if (auto_s && in_acq_s && (overrun_r != OVR_MAX)) begin
                overrun_r <= overrun_r + OVR_ONE;
            end
            if (complete_s || timeout_s) begin
                sched_isr_r <= 1'b1;
            end else if (bus.clr_isr) begin
                sched_isr_r <= 1'b0;
            end
            if (timeout_s) begin
                timeout_isr_r <= 1'b1;
            end else if (bus.clr_isr) begin
                timeout_isr_r <= 1'b0;
            end
        end
    end

    assign bus.trigger     = trigger_r;
    assign bus.busy        = busy_r;
    assign bus.sched_isr   = sched_isr_r;
    assign bus.timeout_isr = timeout_isr_r;
    assign bus.timed_out   = timed_out_r;
    assign bus.ch_time     = ch_time_r;
    assign bus.ch_time_max = ch_time_max_r;
    assign bus.overrun_cnt = overrun_r;

endmodule

// File: tb/tb_sensor_timing_sequencer.sv
// Scoreboard bench for sensor_timing_sequencer: stimulus queues expected triggers and
// acquisition results, a negedge monitor compares them when the DUT presents them.
module tb_sensor_timing_sequencer;

    localparam int NUM_CH  = 10;
    localparam int RATIO_W = 16;
    localparam int TIME_W  = 16;
    localparam int OVR_W   = 8;

    typedef struct {
        logic [15:0] ct0;
        logic [15:0] ct1;
        logic [15:0] mx0;
        logic [15:0] mx1;
        logic [9:0]  tout;
        logic        tisr;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic prev_busy = 1'b0;
    int   checks = 0;
    int   errors = 0;
    res_t exp_res[$];
    int   exp_trig[$];

    sensor_timing_sequencer_if #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W), .TIME_W(TIME_W), .OVR_W(OVR_W)) bus ();

    sensor_timing_sequencer #(.NUM_CH(NUM_CH), .RATIO_W(RATIO_W), .TIME_W(TIME_W), .OVR_W(OVR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_event();
        bus.event_qualifier = 1'b1;
        cycle(1);
        bus.event_qualifier = 1'b0;
    endtask

    task automatic push_res(input logic [15:0] ct0, input logic [15:0] ct1, input logic [15:0] mx0,
                            input logic [15:0] mx1, input logic [9:0] tout, input logic tisr);
        res_t r;
        r.ct0 = ct0; r.ct1 = ct1; r.mx0 = mx0; r.mx1 = mx1; r.tout = tout; r.tisr = tisr;
        exp_res.push_back(r);
    endtask

    // Called in the cycle where tmr==0; raises done bits so they are sampled while tmr==t.
    task automatic set_done_at(input int t, input logic [NUM_CH-1:0] mask);
        cycle(t);
        bus.done = bus.done | mask;
        cycle(1);
    endtask

    task automatic manual_trigger();
        bus.send_manual_trigger = 1'b1;
        cycle(1);
        bus.send_manual_trigger = 1'b0;
        exp_trig.push_back(1);
        pulse_event();
        chk("manual_trigger", bus.trigger, 1);
    endtask

    task automatic pulse_clr_isr();
        bus.clr_isr = 1'b1;
        cycle(1);
        bus.clr_isr = 1'b0;
    endtask

    task automatic pulse_clr_stats();
        bus.clr_stats = 1'b1;
        cycle(1);
        bus.clr_stats = 1'b0;
    endtask

    function automatic logic any_output_set();
        return bus.trigger | bus.busy | bus.sched_isr | bus.timeout_isr | (|bus.timed_out) |
               (|bus.ch_time) | (|bus.ch_time_max) | (|bus.overrun_cnt);
    endfunction

    // Monitor: every trigger must be expected; every end of acquisition is scored.
    always @(negedge clk) begin
        res_t r;
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.trigger) begin
                checks++;
                if (exp_trig.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_trigger: got trigger=1 expected none at %0t", $time);
                end else begin
                    void'(exp_trig.pop_front());
                end
            end
            if (prev_busy && !bus.busy) begin
                if (exp_res.size() == 0) begin
                    chk("unexpected_acq_end", 1, 0);
                end else begin
                    r = exp_res.pop_front();
                    chk("ch_time0", 32'(bus.ch_time[0 +: TIME_W]), 32'(r.ct0));
                    chk("ch_time1", 32'(bus.ch_time[TIME_W +: TIME_W]), 32'(r.ct1));
                    chk("ch_time_max0", 32'(bus.ch_time_max[0 +: TIME_W]), 32'(r.mx0));
                    chk("ch_time_max1", 32'(bus.ch_time_max[TIME_W +: TIME_W]), 32'(r.mx1));
                    chk("timed_out", 32'(bus.timed_out), 32'(r.tout));
                    chk("timeout_isr", 32'(bus.timeout_isr), 32'(r.tisr));
                    chk("sched_isr", 32'(bus.sched_isr), 1);
                end
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.do_auto_triggering  = 1'b0;
        bus.send_manual_trigger = 1'b0;
        bus.event_qualifier     = 1'b0;
        bus.user_ratio          = 16'd0;
        bus.en_bits             = 10'h000;
        bus.done                = 10'h000;
        bus.timeout_cycles      = 16'd0;
        bus.clr_isr             = 1'b0;
        bus.clr_stats           = 1'b0;
        rst = 1'b1;
        cycle(2);
        chk("reset_outputs", 32'(any_output_set()), 0);
        rst = 1'b0;
        cycle(2);

        // 1: auto mode, trigger on every third event; ch0 done at tmr=5
        bus.do_auto_triggering = 1'b1;
        bus.user_ratio         = 16'd2;
        bus.en_bits            = 10'h001;
        pulse_event();
        chk("auto_ev1_no_trig", bus.trigger, 0);
        cycle(2);
        pulse_event();
        chk("auto_ev2_no_trig", bus.trigger, 0);
        cycle(2);
        exp_trig.push_back(1);
        pulse_event();
        chk("auto_ev3_trig", bus.trigger, 1);
        cycle(1);
        chk("trigger_one_cycle", bus.trigger, 0);
        chk("busy_in_acq", bus.busy, 1);
        push_res(16'd5, 16'd0, 16'd5, 16'd0, 10'h000, 1'b0);
        set_done_at(4, 10'h001);
        chk("sched_isr_after_done", bus.sched_isr, 1);
        bus.done = 10'h000;
        pulse_clr_isr();
        chk("sched_isr_cleared", bus.sched_isr, 0);

        // 2: manual request honoured on an event 10 cycles later; held while en_bits==0
        bus.do_auto_triggering  = 1'b0;
        bus.send_manual_trigger = 1'b1;
        cycle(1);
        bus.send_manual_trigger = 1'b0;
        cycle(10);
        exp_trig.push_back(1);
        pulse_event();
        chk("manual_late_event_trig", bus.trigger, 1);
        push_res(16'd3, 16'd0, 16'd5, 16'd0, 10'h000, 1'b0);
        set_done_at(3, 10'h001);
        bus.done    = 10'h000;
        bus.en_bits = 10'h000;
        bus.send_manual_trigger = 1'b1;
        cycle(1);
        bus.send_manual_trigger = 1'b0;
        cycle(2);
        pulse_event();
        chk("no_trig_en_zero", bus.trigger, 0);
        bus.en_bits = 10'h001;
        cycle(1);
        exp_trig.push_back(1);
        pulse_event();
        chk("mq_held_trig", bus.trigger, 1);
        push_res(16'd2, 16'd0, 16'd5, 16'd0, 10'h000, 1'b0);
        set_done_at(2, 10'h001);
        bus.done = 10'h000;

        // 3: timeout at tmr=20 with ch1 missing
        bus.en_bits        = 10'h003;
        bus.timeout_cycles = 16'd20;
        manual_trigger();
        push_res(16'd4, 16'hFFFF, 16'd5, 16'd0, 10'h002, 1'b1);
        set_done_at(4, 10'h001);
        cycle(15);
        chk("busy_before_timeout", bus.busy, 1);
        cycle(1);
        chk("idle_after_timeout", bus.busy, 0);
        bus.done = 10'h000;
        pulse_clr_isr();
        chk("timeout_isr_cleared", bus.timeout_isr, 0);
        bus.timeout_cycles = 16'd0;
        bus.en_bits        = 10'h001;

        // 5: worst-case tracking 7, 3, 9 and done held across a trigger
        pulse_clr_stats();
        manual_trigger();
        push_res(16'd7, 16'hFFFF, 16'd7, 16'd0, 10'h000, 1'b0);
        set_done_at(7, 10'h001);
        bus.done = 10'h000;
        manual_trigger();
        push_res(16'd3, 16'hFFFF, 16'd7, 16'd0, 10'h000, 1'b0);
        set_done_at(3, 10'h001);
        bus.done = 10'h000;
        manual_trigger();
        push_res(16'd9, 16'hFFFF, 16'd9, 16'd0, 10'h000, 1'b0);
        set_done_at(9, 10'h001);
        manual_trigger();
        cycle(4);
        chk("held_done_no_capture", bus.busy, 1);
        bus.done = 10'h000;
        push_res(16'd5, 16'hFFFF, 16'd9, 16'd0, 10'h000, 1'b0);
        cycle(1);
        bus.done = 10'h001;
        cycle(1);
        bus.done = 10'h000;

        // 4: overrun counting and saturation with ratio 0
        bus.do_auto_triggering = 1'b1;
        bus.user_ratio         = 16'd0;
        exp_trig.push_back(1);
        pulse_event();
        chk("auto_ratio0_trig", bus.trigger, 1);
        for (int i = 0; i < 3; i++) pulse_event();
        chk("overrun_3", 32'(bus.overrun_cnt), 3);
        for (int i = 0; i < 260; i++) pulse_event();
        chk("overrun_saturated", 32'(bus.overrun_cnt), 255);
        pulse_clr_stats();
        chk("overrun_cleared", 32'(bus.overrun_cnt), 0);
        chk("busy_still_acq", bus.busy, 1);

        // 6: asynchronous reset in the middle of an acquisition
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(any_output_set()), 0);
        cycle(2);
        rst = 1'b0;
        cycle(3);
        chk("post_reset_idle", bus.busy, 0);
        exp_trig.push_back(1);
        pulse_event();
        chk("post_reset_trig", bus.trigger, 1);
        cycle(3);

        chk("trig_queue_empty", 32'(exp_trig.size()), 0);
        chk("res_queue_empty", 32'(exp_res.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
